boot_sequencer: RTL and testbench
=================================

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 10: cycles the CPU is held in reset after load completes; legal range 1..255.
REQ-002 The block SHALL have parameter BASE_ADDR, default 8'h00: PC value presented at CPU start.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-low block reset.
REQ-005 boot_req  in  1  single-cycle pulse requesting a fresh program load.
REQ-006 load_valid  in  1  a program byte is offered on load_data.
REQ-007 load_data  in  8  program byte.
REQ-008 load_last  in  1  the offered byte is the final byte of the image.
REQ-009 load_ready  out  1  sequencer accepts a byte this cycle.
REQ-010 rom_we  out  1  ROM write strobe.
REQ-011 rom_addr  out  8  ROM write address.
REQ-012 rom_wdata  out  8  ROM write data.
REQ-013 pc_load  out  1  one-cycle strobe forcing the CPU PC to pc_value.
REQ-014 pc_value  out  8  constant BASE_ADDR.
REQ-015 cpu_reset  out  1  active-low CPU reset; 0 = CPU held, 1 = CPU runs.
REQ-016 boot_done  out  1  high while the CPU runs the loaded image.
REQ-017 boot_error  out  1  sticky image-overflow flag.
REQ-018 byte_count  out  9  bytes written in the current load, 0..256.

Function
REQ-019 The FSM SHALL have exactly the states LOAD, HOLD, PCSET, RUN and ERROR.
REQ-020 All outputs SHALL be registered, with load_ready = (next state == LOAD).
REQ-021 A byte SHALL transfer only in a cycle with load_valid=1 and load_ready=1; load_valid with load_ready=0 has no effect.
REQ-022 For a transfer at edge T, rom_we SHALL be 1 for exactly cycle T+1, with rom_addr = byte_count before T (low 8 bits) and rom_wdata = load_data; byte_count SHALL increment at T.
REQ-023 rom_we SHALL be 0 in every cycle that does not follow a transfer; rom_addr/rom_wdata SHALL hold their last values.
REQ-024 A transfer with load_last=1 SHALL move LOAD->HOLD at T, so load_ready=0 from T+1.
REQ-025 HOLD SHALL last exactly HOLD_CYCLES cycles (internal 8-bit counter), then move to PCSET.
REQ-026 PCSET SHALL last one cycle with pc_load=1, then move to RUN.
REQ-027 For a last-byte transfer at T: HOLD SHALL span T+1..T+HOLD_CYCLES, pc_load=1 SHALL occur at T+HOLD_CYCLES+1, and cpu_reset=1 and boot_done=1 SHALL hold from T+HOLD_CYCLES+2.
REQ-028 cpu_reset SHALL be 0 in LOAD, HOLD, PCSET and ERROR, and 1 only in RUN; boot_done SHALL be 1 only in RUN.
REQ-029 Overflow: a 256th transfer with load_last=0 SHALL still write address 8'hFF, set byte_count=256, and move to ERROR; boot_error=1 from T+1.
REQ-030 A 256th transfer with load_last=1 SHALL be legal and move to HOLD.
REQ-031 In ERROR, load_ready SHALL be 0 and boot_error SHALL stay 1 until boot_req or reset.
REQ-032 boot_req in HOLD, PCSET, RUN or ERROR SHALL force LOAD next cycle: byte_count=0, boot_error=0, boot_done=0, cpu_reset=0, HOLD counter cleared.
REQ-033 boot_req SHALL take priority over every simultaneous transition, e.g. the final HOLD cycle or the PCSET exit.
REQ-034 boot_req in LOAD SHALL be ignored, and a simultaneous byte transfer SHALL proceed normally.

Reset
REQ-035 Asserting reset low SHALL immediately force state LOAD, byte_count=0, rom_we=0, rom_addr=0, rom_wdata=0, pc_load=0, cpu_reset=0, boot_done=0, boot_error=0, load_ready=0 and clear the HOLD counter, regardless of the clock.
REQ-036 load_ready SHALL become 1 at the first rising edge after reset deasserts.
REQ-037 Reset mid-load SHALL discard the partial image count; ROM contents are not cleared.

Verification
REQ-038 Load 3 bytes 0x11,0x22,0x33 back-to-back with last on 0x33 -> rom_we writes 00:11, 01:22, 02:33 on consecutive cycles; pc_load 11 cycles after the last transfer; cpu_reset=1 one cycle later; byte_count=3.
REQ-039 Same image with load_valid toggling every other cycle -> identical ROM writes, no duplicate or dropped bytes, byte_count=3.
REQ-040 256 bytes with load_last never set -> write at address FF, boot_error=1, byte_count=256, load_ready=0, cpu_reset stays 0; boot_req -> LOAD, boot_error=0, byte_count=0.
REQ-041 boot_req on the 10th HOLD cycle -> no pc_load, LOAD next cycle, cpu_reset stays 0.
REQ-042 boot_req while in RUN -> cpu_reset=0 and boot_done=0 next cycle; a 1-byte reload with last -> RUN again after HOLD_CYCLES+2 cycles.
REQ-043 reset asserted mid-HOLD, between clock edges -> all outputs at reset values immediately; load_ready=1 one edge after release.

Source files
------------

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - loads a program image into ROM, holds the CPU in reset, then releases it at BASE_ADDR
module boot_sequencer #(
  parameter int          HOLD_CYCLES = 10,
  parameter logic [7:0]  BASE_ADDR   = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       boot_req,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       rom_we,
  output logic [7:0] rom_addr,
  output logic [7:0] rom_wdata,
  output logic       pc_load,
  output logic [7:0] pc_value,
  output logic       cpu_reset,
  output logic       boot_done,
  output logic       boot_error,
  output logic [8:0] byte_count
);

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    HOLD  = 3'd1,
    PCSET = 3'd2,
    RUN   = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  state_t     state;
  state_t     state_next;
  logic [7:0] hold_cnt;
  logic       xfer;
  logic       restart;

  assign pc_value = BASE_ADDR;

  always_comb begin
    state_next = state;
    xfer       = load_valid && load_ready;
    restart    = boot_req && (state != LOAD);
    case (state)
      LOAD: begin
        if (xfer) begin
          if (load_last)                state_next = HOLD;
          else if (byte_count == 9'd255) state_next = ERROR;
        end
      end
      HOLD: begin
        if (boot_req)                   state_next = LOAD;
        else if (hold_cnt == HOLD_LAST) state_next = PCSET;
      end
      PCSET:   state_next = boot_req ? LOAD : RUN;
      RUN:     if (boot_req) state_next = LOAD;
      ERROR:   if (boot_req) state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Every status output is a registered decode of the state being entered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      hold_cnt   <= 8'd0;
      byte_count <= 9'd0;
      load_ready <= 1'b0;
      rom_we     <= 1'b0;
      rom_addr   <= 8'd0;
      rom_wdata  <= 8'd0;
      pc_load    <= 1'b0;
      cpu_reset  <= 1'b0;
      boot_done  <= 1'b0;
      boot_error <= 1'b0;
    end else begin
      state      <= state_next;
      load_ready <= (state_next == LOAD);
      pc_load    <= (state_next == PCSET);
      cpu_reset  <= (state_next == RUN);
      boot_done  <= (state_next == RUN);
      boot_error <= (state_next == ERROR);
      rom_we     <= xfer;
      if (xfer) begin
        rom_addr  <= byte_count[7:0];
        rom_wdata <= load_data;
      end
      if (restart)   byte_count <= 9'd0;
      else if (xfer) byte_count <= byte_count + 9'd1;
      if (state == HOLD && state_next == HOLD) hold_cnt <= hold_cnt + 8'd1;
      else                                     hold_cnt <= 8'd0;
    end
  end

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed self-checking bench for boot_sequencer
module tb_boot_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       boot_req = 1'b0;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = 8'h00;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       rom_we;
  logic [7:0] rom_addr;
  logic [7:0] rom_wdata;
  logic       pc_load;
  logic [7:0] pc_value;
  logic       cpu_reset;
  logic       boot_done;
  logic       boot_error;
  logic [8:0] byte_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];

  boot_sequencer #(.HOLD_CYCLES(10), .BASE_ADDR(8'h00)) dut (
    .clk(clk), .reset(reset), .boot_req(boot_req), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .pc_load(pc_load), .pc_value(pc_value), .cpu_reset(cpu_reset),
    .boot_done(boot_done), .boot_error(boot_error), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (rom_we === 1'b1) begin
      wr_addr.push_back(rom_addr);
      wr_data.push_back(rom_wdata);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic br);
    load_valid = v;
    load_data  = d;
    load_last  = l;
    boot_req   = br;
    step();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  logic bad;

  initial begin
    // reset state
    #3 reset = 1'b0;
    #1;
    check("rst_ready", load_ready, 0);
    check("rst_we", rom_we, 0);
    check("rst_cpu", cpu_reset, 0);
    check("rst_done", boot_done, 0);
    check("rst_err", boot_error, 0);
    check("rst_cnt", byte_count, 0);
    check("rst_pcload", pc_load, 0);
    check("pc_value", pc_value, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ready_before_edge", load_ready, 0);
    step();
    check("ready_after_release", load_ready, 1);

    // three bytes back-to-back
    clear_log();
    drive(1'b1, 8'h11, 1'b0, 1'b0);
    check("b2b_we0", rom_we, 1);
    check("b2b_addr0", rom_addr, 8'h00);
    check("b2b_data0", rom_wdata, 8'h11);
    check("b2b_cnt0", byte_count, 1);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    check("b2b_addr1", rom_addr, 8'h01);
    check("b2b_data1", rom_wdata, 8'h22);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    check("b2b_addr2", rom_addr, 8'h02);
    check("b2b_data2", rom_wdata, 8'h33);
    check("b2b_cnt3", byte_count, 3);
    check("b2b_ready_off", load_ready, 0);
    bad = 1'b0;
    for (int k = 0; k < 9; k++) begin
      drive(1'b1, 8'hEE, 1'b0, 1'b0);
      bad |= pc_load | cpu_reset | rom_we;
    end
    check("hold_quiet", bad, 0);
    idle(1);
    check("pcload_at_h1", pc_load, 1);
    check("pcset_cpu_held", cpu_reset, 0);
    idle(1);
    check("pcload_pulse", pc_load, 0);
    check("run_cpu", cpu_reset, 1);
    check("run_done", boot_done, 1);
    check("run_cnt", byte_count, 3);
    check("b2b_writes", wr_addr.size(), 3);

    // boot_req in RUN, one-byte reload
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("rerun_cpu", cpu_reset, 0);
    check("rerun_done", boot_done, 0);
    check("rerun_ready", load_ready, 1);
    check("rerun_cnt", byte_count, 0);
    drive(1'b1, 8'h7E, 1'b1, 1'b0);
    check("one_addr", rom_addr, 8'h00);
    check("one_data", rom_wdata, 8'h7E);
    check("one_cnt", byte_count, 1);
    idle(10);
    check("one_pcload", pc_load, 1);
    idle(1);
    check("one_run", cpu_reset, 1);
    check("one_done", boot_done, 1);

    // toggling valid, boot_req in LOAD ignored
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    clear_log();
    drive(1'b1, 8'h11, 1'b0, 1'b1);
    check("tog_cnt1", byte_count, 1);
    check("tog_ready", load_ready, 1);
    drive(1'b0, 8'hEE, 1'b0, 1'b0);
    check("tog_we_gap", rom_we, 0);
    check("tog_hold_data", rom_wdata, 8'h11);
    drive(1'b1, 8'h22, 1'b0, 1'b0);
    drive(1'b0, 8'hEE, 1'b1, 1'b0);
    drive(1'b1, 8'h33, 1'b1, 1'b0);
    check("tog_writes", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("tog_a0", {wr_addr[0], wr_data[0]}, 16'h0011);
      check("tog_a1", {wr_addr[1], wr_data[1]}, 16'h0122);
      check("tog_a2", {wr_addr[2], wr_data[2]}, 16'h0233);
    end
    check("tog_cnt3", byte_count, 3);

    // boot_req on the 10th HOLD cycle
    idle(9);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("abort_pcload", pc_load, 0);
    check("abort_ready", load_ready, 1);
    check("abort_cpu", cpu_reset, 0);
    check("abort_cnt", byte_count, 0);
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      bad |= pc_load | cpu_reset;
    end
    check("abort_quiet", bad, 0);

    // overflow: 256 bytes without last
    clear_log();
    for (int i = 0; i < 256; i++) drive(1'b1, 8'(i) ^ 8'hA5, 1'b0, 1'b0);
    check("ovf_writes", wr_addr.size(), 256);
    bad = 1'b0;
    for (int i = 0; i < wr_addr.size(); i++)
      bad |= (wr_addr[i] != 8'(i)) || (wr_data[i] != (8'(i) ^ 8'hA5));
    check("ovf_sequence", bad, 0);
    check("ovf_last_addr", rom_addr, 8'hFF);
    check("ovf_last_data", rom_wdata, 8'h5A);
    check("ovf_err", boot_error, 1);
    check("ovf_cnt", byte_count, 256);
    check("ovf_ready", load_ready, 0);
    check("ovf_cpu", cpu_reset, 0);
    drive(1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 8'h02, 1'b1, 1'b0);
    check("ovf_no_more", wr_addr.size(), 256);
    check("ovf_sticky", boot_error, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clr_err", boot_error, 0);
    check("ovf_clr_cnt", byte_count, 0);
    check("ovf_clr_ready", load_ready, 1);

    // 256 bytes with last on the final one
    clear_log();
    for (int i = 0; i < 256; i++) drive(1'b1, 8'(i), (i == 255), 1'b0);
    check("full_err", boot_error, 0);
    check("full_cnt", byte_count, 256);
    check("full_ready", load_ready, 0);
    check("full_addr", rom_addr, 8'hFF);
    idle(10);
    check("full_pcload", pc_load, 1);
    idle(1);
    check("full_run", cpu_reset, 1);

    // asynchronous reset mid-HOLD
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    drive(1'b1, 8'hC3, 1'b0, 1'b0);
    drive(1'b1, 8'h5C, 1'b1, 1'b0);
    check("mid_addr", rom_addr, 8'h01);
    check("mid_cnt", byte_count, 2);
    idle(3);
    load_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("ar_ready", load_ready, 0);
    check("ar_we", rom_we, 0);
    check("ar_addr", rom_addr, 8'h00);
    check("ar_data", rom_wdata, 8'h00);
    check("ar_pcload", pc_load, 0);
    check("ar_cpu", cpu_reset, 0);
    check("ar_done", boot_done, 0);
    check("ar_err", boot_error, 0);
    check("ar_cnt", byte_count, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("ar_ready_pre", load_ready, 0);
    step();
    check("ar_ready_post", load_ready, 1);
    drive(1'b1, 8'h99, 1'b1, 1'b0);
    check("ar_reload_addr", rom_addr, 8'h00);
    check("ar_reload_cnt", byte_count, 1);
    idle(9);
    check("ar_hold_fresh", pc_load, 0);
    idle(1);
    check("ar_pcload", pc_load, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
